// File: rtl/pwm_ramp_sequencer.sv
// pwm_ramp_sequencer: ramps PWM duty min->max->min with dwell, updating only on period boundaries
module pwm_ramp_sequencer #(
    parameter int W      = 32,
    parameter int HOLD_W = 16,
    parameter int CYC_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [W-1:0]      cfg_period,
    input  logic [W-1:0]      cfg_min,
    input  logic [W-1:0]      cfg_max,
    input  logic [W-1:0]      cfg_step,
    input  logic [HOLD_W-1:0] cfg_hold,
    input  logic [CYC_W-1:0]  cfg_cycles,
    input  logic              stop,
    output logic [W-1:0]      pwm_hi,
    output logic [W-1:0]      pwm_rst,
    output logic              period_tick,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, RAMP_UP, HOLD_HI, RAMP_DOWN, HOLD_LO} state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      duty_q, duty_d;
    logic [W-1:0]      prd_q, prd_d;
    logic [W-1:0]      min_q, min_d;
    logic [W-1:0]      max_q, max_d;
    logic [W-1:0]      step_q, step_d;
    logic [W-1:0]      cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W-1:0] hcnt_q, hcnt_d;
    logic [CYC_W-1:0]  cycles_q, cycles_d;
    logic [CYC_W-1:0]  cdone_q, cdone_d;
    logic              tick_q, tick_d;
    logic              done_q, done_d;
    logic              wrap, hold_hit, last_cyc, eoc;
    logic [W:0]        up_sum;

    assign busy        = state_q != IDLE;
    assign cfg_ready   = state_q == IDLE;
    assign pwm_hi      = duty_q;
    assign pwm_rst     = prd_q;
    assign period_tick = tick_q;
    assign done        = done_q;

    // the last clock of a period is the boundary where duty/state may change
    assign wrap     = busy && cnt_q == prd_q;
    assign hold_hit = hcnt_q + HOLD_W'(1) == hold_q;
    assign last_cyc = cycles_q != '0 && cdone_q + CYC_W'(1) == cycles_q;
    // one extra bit so a ramp near the top of the range saturates instead of wrapping
    assign up_sum   = {1'b0, duty_q} + {1'b0, step_q};

    // period counter runs 0..pwm_rst while busy; cleared on stop so the next run starts aligned
    always_comb begin
        cnt_d  = (busy && !wrap && !stop) ? cnt_q + W'(1) : '0;
        tick_d = wrap;
    end

    // sequencing FSM: accept/sanitise config, then step duty and dwell on period boundaries
    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        prd_d    = prd_q;
        min_d    = min_q;
        max_d    = max_q;
        step_d   = step_q;
        hold_d   = hold_q;
        hcnt_d   = hcnt_q;
        cycles_d = cycles_q;
        cdone_d  = cdone_q;
        done_d   = 1'b0;
        eoc      = 1'b0;
        if (state_q == IDLE) begin
            duty_d = '0;
            if (cfg_valid) begin
                state_d  = RAMP_UP;
                duty_d   = cfg_min;
                prd_d    = cfg_period;
                min_d    = cfg_min;
                max_d    = (cfg_max < cfg_min) ? cfg_min : cfg_max;
                step_d   = (cfg_step == '0) ? W'(1) : cfg_step;
                hold_d   = cfg_hold;
                cycles_d = cfg_cycles;
                hcnt_d   = '0;
                cdone_d  = '0;
            end
        end else if (stop) begin
            state_d = IDLE;
            duty_d  = '0;
        end else if (wrap) begin
            case (state_q)
                RAMP_UP: begin
                    if (duty_q == max_q) begin
                        state_d = (hold_q == '0) ? RAMP_DOWN : HOLD_HI;
                        hcnt_d  = '0;
                    end else begin
                        duty_d = (up_sum > {1'b0, max_q}) ? max_q : up_sum[W-1:0];
                    end
                end
                HOLD_HI: begin
                    hcnt_d  = hold_hit ? '0 : hcnt_q + HOLD_W'(1);
                    state_d = hold_hit ? RAMP_DOWN : HOLD_HI;
                end
                RAMP_DOWN: begin
                    if (duty_q == min_q) begin
                        state_d = HOLD_LO;
                        hcnt_d  = '0;
                        eoc     = hold_q == '0;
                    end else begin
                        duty_d = (duty_q - min_q <= step_q) ? min_q : duty_q - step_q;
                    end
                end
                HOLD_LO: begin
                    hcnt_d = hold_hit ? '0 : hcnt_q + HOLD_W'(1);
                    eoc    = hold_hit;
                end
                default: state_d = IDLE;
            endcase
            if (eoc) begin
                state_d = last_cyc ? IDLE : RAMP_UP;
                duty_d  = last_cyc ? '0 : duty_q;
                done_d  = last_cyc;
                cdone_d = last_cyc ? cdone_q : cdone_q + CYC_W'(1);
            end
        end
    end

    // state and configuration registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            duty_q   <= '0;
            prd_q    <= '0;
            min_q    <= '0;
            max_q    <= '0;
            step_q   <= '0;
            cnt_q    <= '0;
            hold_q   <= '0;
            hcnt_q   <= '0;
            cycles_q <= '0;
            cdone_q  <= '0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            prd_q    <= prd_d;
            min_q    <= min_d;
            max_q    <= max_d;
            step_q   <= step_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            hcnt_q   <= hcnt_d;
            cycles_q <= cycles_d;
            cdone_q  <= cdone_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// tb_pwm_ramp_sequencer: scoreboard bench comparing duty at each period tick against a reference ramp
module tb_pwm_ramp_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_period = '0, cfg_min = '0, cfg_max = '0, cfg_step = '0;
    logic [15:0] cfg_hold = '0, cfg_cycles = '0;
    logic        stop = 1'b0;
    logic [31:0] pwm_hi, pwm_rst;
    logic        period_tick, busy, done;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int done_cnt = 0;
    int acc_cyc = 0;
    logic [31:0] exp_q[$];

    pwm_ramp_sequencer dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_period(cfg_period), .cfg_min(cfg_min), .cfg_max(cfg_max), .cfg_step(cfg_step),
        .cfg_hold(cfg_hold), .cfg_cycles(cfg_cycles), .stop(stop),
        .pwm_hi(pwm_hi), .pwm_rst(pwm_rst), .period_tick(period_tick), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // clock count for latency checks and done-pulse tally
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic accept(input logic [31:0] per, mn, mx, st, input logic [15:0] hold, cyc);
        @(negedge clk);
        cfg_period = per; cfg_min = mn; cfg_max = mx; cfg_step = st;
        cfg_hold = hold; cfg_cycles = cyc; cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        acc_cyc = cyc_cnt;
    endtask

    task automatic wait_tick(output bit ok, output bit stable);
        logic [31:0] p;
        p = pwm_hi; ok = 1'b0; stable = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (period_tick) begin
                ok = 1'b1;
                break;
            end
            if (pwm_hi !== p) stable = 1'b0;
        end
    endtask

    // reference ramp: expected duty seen after each period tick over one full up/down cycle
    task automatic push_cycle(input logic [31:0] mn, mx, st, input int hold, input bit last);
        logic [32:0] s;
        logic [31:0] d;
        if (st == 0) st = 1;
        if (mx < mn) mx = mn;
        d = mn;
        while (d != mx) begin
            s = {1'b0, d} + {1'b0, st};
            d = (s > {1'b0, mx}) ? mx : s[31:0];
            exp_q.push_back(d);
        end
        exp_q.push_back(d);
        repeat (hold) exp_q.push_back(d);
        while (d != mn) begin
            d = (d - mn <= st) ? mn : d - st;
            exp_q.push_back(d);
        end
        exp_q.push_back(d);
        repeat (hold) exp_q.push_back(d);
        if (last) begin
            void'(exp_q.pop_back());
            exp_q.push_back(32'd0);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (pwm_hi !== 0 || pwm_rst !== 0 || busy !== 0 || done !== 0 || period_tick !== 0 || cfg_ready !== 1) begin
            errors++;
            $display("FAIL reset_state hi=%h rst=%h busy=%b done=%b tick=%b ready=%b want 0 0 0 0 0 1",
                     pwm_hi, pwm_rst, busy, done, period_tick, cfg_ready);
        end
        accept(32'd9, 32'd3, 32'd10, 32'd1, 16'd1, 16'd1);
        repeat (12) @(negedge clk);
        checks++;
        if (busy !== 1 || pwm_hi !== 32'd4 || pwm_rst !== 32'd9) begin
            errors++;
            $display("FAIL reset_pre busy=%b hi=%0d rst=%0d want 1 4 9", busy, pwm_hi, pwm_rst);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (pwm_hi !== 0 || pwm_rst !== 0 || busy !== 0 || cfg_ready !== 1 || done !== 0) begin
            errors++;
            $display("FAIL reset_mid hi=%h rst=%h busy=%b ready=%b done=%b want 0 0 0 1 0",
                     pwm_hi, pwm_rst, busy, cfg_ready, done);
        end
    endtask

    task automatic test_basic;
        bit ok, stable;
        int last;
        logic [31:0] e;
        done_cnt = 0;
        accept(32'd9, 32'd0, 32'd4, 32'd2, 16'd1, 16'd1);
        checks++;
        if (busy !== 1 || cfg_ready !== 0 || pwm_hi !== 0 || pwm_rst !== 32'd9) begin
            errors++;
            $display("FAIL basic_accept busy=%b ready=%b hi=%0d rst=%0d want 1 0 0 9", busy, cfg_ready, pwm_hi, pwm_rst);
        end
        foreach (exp_q[i]) exp_q.delete(i);
        exp_q.push_back(32'd2); exp_q.push_back(32'd4); exp_q.push_back(32'd4); exp_q.push_back(32'd4);
        exp_q.push_back(32'd2); exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        last = acc_cyc;
        while (exp_q.size() > 0) begin
            wait_tick(ok, stable);
            e = exp_q.pop_front();
            checks++;
            if (!ok || !stable || pwm_hi !== e || cyc_cnt - last != 10) begin
                errors++;
                $display("FAIL basic_duty got %0d want %0d tick=%b stable=%b spacing=%0d want 10",
                         pwm_hi, e, ok, stable, cyc_cnt - last);
            end
            last = cyc_cnt;
        end
        checks++;
        if (done !== 1 || busy !== 0 || cyc_cnt - acc_cyc != 80) begin
            errors++;
            $display("FAIL basic_done done=%b busy=%b latency=%0d want 1 0 80", done, busy, cyc_cnt - acc_cyc);
        end
        @(negedge clk);
        checks++;
        if (done !== 0 || cfg_ready !== 1 || done_cnt != 1) begin
            errors++;
            $display("FAIL basic_done_once done=%b ready=%b count=%0d want 0 1 1", done, cfg_ready, done_cnt);
        end
    endtask

    task automatic test_saturation;
        bit ok, stable;
        logic [31:0] e, peak;
        peak = '0;
        push_cycle(32'hFFFF_FF05, 32'hFFFF_FFF0, 32'h20, 0, 1'b1);
        accept(32'd0, 32'hFFFF_FF05, 32'hFFFF_FFF0, 32'h20, 16'd0, 16'd1);
        while (exp_q.size() > 0) begin
            wait_tick(ok, stable);
            e = exp_q.pop_front();
            if (pwm_hi > peak) peak = pwm_hi;
            checks++;
            if (!ok || pwm_hi !== e) begin
                errors++;
                $display("FAIL sat_duty got %h want %h tick=%b", pwm_hi, e, ok);
            end
        end
        checks++;
        if (peak !== 32'hFFFF_FFF0) begin
            errors++;
            $display("FAIL sat_peak got %h want fffffff0", peak);
        end
        push_cycle(32'd5, 32'd30, 32'd8, 2, 1'b1);
        accept(32'd2, 32'd5, 32'd30, 32'd8, 16'd2, 16'd1);
        while (exp_q.size() > 0) begin
            wait_tick(ok, stable);
            e = exp_q.pop_front();
            checks++;
            if (!ok || !stable || pwm_hi !== e) begin
                errors++;
                $display("FAIL floor_duty got %0d want %0d tick=%b stable=%b", pwm_hi, e, ok, stable);
            end
        end
    endtask

    task automatic test_sanitise;
        bit ok, stable;
        logic [31:0] e;
        push_cycle(32'd0, 32'd3, 32'd0, 0, 1'b1);
        accept(32'd1, 32'd0, 32'd3, 32'd0, 16'd0, 16'd1);
        while (exp_q.size() > 0) begin
            wait_tick(ok, stable);
            e = exp_q.pop_front();
            checks++;
            if (!ok || !stable || pwm_hi !== e) begin
                errors++;
                $display("FAIL step0_duty got %0d want %0d tick=%b stable=%b", pwm_hi, e, ok, stable);
            end
        end
        push_cycle(32'd7, 32'd3, 32'd2, 0, 1'b0);
        push_cycle(32'd7, 32'd3, 32'd2, 0, 1'b1);
        done_cnt = 0;
        accept(32'd1, 32'd7, 32'd3, 32'd2, 16'd0, 16'd2);
        while (exp_q.size() > 0) begin
            wait_tick(ok, stable);
            e = exp_q.pop_front();
            checks++;
            if (!ok || pwm_hi !== e) begin
                errors++;
                $display("FAIL maxmin_duty got %0d want %0d tick=%b", pwm_hi, e, ok);
            end
        end
        checks++;
        if (done !== 1 || busy !== 0) begin
            errors++;
            $display("FAIL maxmin_done done=%b busy=%b want 1 0", done, busy);
        end
    endtask

    task automatic test_forever_stop;
        bit ok, stable;
        logic [31:0] e;
        repeat (4) push_cycle(32'd0, 32'd2, 32'd1, 0, 1'b0);
        exp_q.push_back(32'd1); exp_q.push_back(32'd2); exp_q.push_back(32'd2);
        @(negedge clk);
        done_cnt = 0;
        accept(32'd0, 32'd0, 32'd2, 32'd1, 16'd0, 16'd0);
        while (exp_q.size() > 0) begin
            wait_tick(ok, stable);
            e = exp_q.pop_front();
            checks++;
            if (!ok || pwm_hi !== e || busy !== 1) begin
                errors++;
                $display("FAIL forever_duty got %0d want %0d busy=%b tick=%b", pwm_hi, e, busy, ok);
            end
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if (pwm_hi !== 0 || busy !== 0 || done !== 0 || cfg_ready !== 1) begin
            errors++;
            $display("FAIL stop_down hi=%0d busy=%b done=%b ready=%b want 0 0 0 1", pwm_hi, busy, done, cfg_ready);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt != 0 || busy !== 0) begin
            errors++;
            $display("FAIL stop_no_done count=%0d busy=%b want 0 0", done_cnt, busy);
        end
    endtask

    task automatic test_back_to_back;
        bit ok, stable;
        logic [31:0] e;
        push_cycle(32'd1, 32'd2, 32'd1, 0, 1'b1);
        @(negedge clk);
        cfg_period = 32'd3; cfg_min = 32'd1; cfg_max = 32'd2; cfg_step = 32'd1;
        cfg_hold = 16'd0; cfg_cycles = 16'd1; cfg_valid = 1'b1;
        @(negedge clk);
        cfg_period = 32'd5; cfg_min = 32'd9; cfg_max = 32'd12; cfg_step = 32'd1; cfg_cycles = 16'd1;
        while (exp_q.size() > 0) begin
            wait_tick(ok, stable);
            e = exp_q.pop_front();
            checks++;
            if (!ok || !stable || pwm_hi !== e || pwm_rst !== 32'd3) begin
                errors++;
                $display("FAIL b2b_duty got %0d/%0d want %0d/3 tick=%b stable=%b", pwm_hi, pwm_rst, e, ok, stable);
            end
        end
        checks++;
        if (done !== 1 || cfg_ready !== 1 || busy !== 0) begin
            errors++;
            $display("FAIL b2b_done done=%b ready=%b busy=%b want 1 1 0", done, cfg_ready, busy);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        checks++;
        if (busy !== 1 || pwm_rst !== 32'd5 || pwm_hi !== 32'd9 || done !== 0) begin
            errors++;
            $display("FAIL b2b_reaccept busy=%b rst=%0d hi=%0d done=%b want 1 5 9 0", busy, pwm_rst, pwm_hi, done);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_saturation;
        test_sanitise;
        test_forever_stop;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
